// File: rtl/debug_timer_sequencer.sv
// Programs a memory-mapped interval timer: boot period, round-robin period requests, irq servicing.
// Optional TIMER_SEQ_STATS_EN builds the serviced-timeout counter behind expired_count.
module debug_timer_sequencer #(
    parameter logic [31:0] BOOT_PERIOD = 32'd49999,
    parameter logic [15:0] CTRL_WORD   = 16'h0007
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_period,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_period,
    output logic        req1_ready,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_irq,
    output logic        quantum_expired,
    output logic [31:0] cur_period,
    output logic        cur_owner,
    output logic        busy,
    output logic [15:0] expired_count
);

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        CLR_STS
    } state_t;

    state_t      state_q;
    logic [31:0] period_q;
    logic        owner_q;
    logic        last_q;
    logic [2:0]  addr_q;
    logic        cs_q;
    logic        wn_q;
    logic [15:0] wd_q;
    logic        qe_q;
    logic [31:0] cur_period_q;
    logic        cur_owner_q;

    logic        arb_en;
    logic        win1;
    logic        grant0;
    logic        grant1;
    logic [31:0] acc_raw;
    logic [31:0] acc_period;

    // irq outranks requests; on a tie the requester not granted last wins
    assign arb_en     = (state_q == IDLE) && !tmr_irq;
    assign win1       = req1_valid && (!req0_valid || !last_q);
    assign grant1     = arb_en && win1;
    assign grant0     = arb_en && req0_valid && !win1;
    assign acc_raw    = win1 ? req1_period : req0_period;
    assign acc_period = (acc_raw == 32'd0) ? 32'd1 : acc_raw;

    assign req0_ready      = grant0;
    assign req1_ready      = grant1;
    assign tmr_address     = addr_q;
    assign tmr_chipselect  = cs_q;
    assign tmr_write_n     = wn_q;
    assign tmr_writedata   = wd_q;
    assign quantum_expired = qe_q;
    assign cur_period      = cur_period_q;
    assign cur_owner       = cur_owner_q;
    assign busy            = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            period_q     <= 32'd0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            addr_q       <= 3'd0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wd_q         <= 16'd0;
            qe_q         <= 1'b0;
            cur_period_q <= 32'd0;
            cur_owner_q  <= 1'b0;
        end else begin
            addr_q <= 3'd0;
            cs_q   <= 1'b0;
            wn_q   <= 1'b1;
            wd_q   <= 16'd0;
            qe_q   <= 1'b0;
            unique case (state_q)
                BOOT: begin
                    period_q <= BOOT_PERIOD;
                    owner_q  <= 1'b0;
                    state_q  <= WR_PL;
                    addr_q   <= 3'd2;
                    cs_q     <= 1'b1;
                    wn_q     <= 1'b0;
                    wd_q     <= BOOT_PERIOD[15:0];
                end
                IDLE: begin
                    if (tmr_irq) begin
                        state_q <= CLR_STS;
                        addr_q  <= 3'd0;
                        cs_q    <= 1'b1;
                        wn_q    <= 1'b0;
                        wd_q    <= 16'd0;
                        qe_q    <= 1'b1;
                    end else if (grant0 || grant1) begin
                        period_q <= acc_period;
                        owner_q  <= win1;
                        last_q   <= win1;
                        state_q  <= WR_PL;
                        addr_q   <= 3'd2;
                        cs_q     <= 1'b1;
                        wn_q     <= 1'b0;
                        wd_q     <= acc_period[15:0];
                    end
                end
                WR_PL: begin
                    state_q <= WR_PH;
                    addr_q  <= 3'd3;
                    cs_q    <= 1'b1;
                    wn_q    <= 1'b0;
                    wd_q    <= period_q[31:16];
                end
                WR_PH: begin
                    state_q      <= WR_CTRL;
                    addr_q       <= 3'd1;
                    cs_q         <= 1'b1;
                    wn_q         <= 1'b0;
                    wd_q         <= CTRL_WORD;
                    cur_period_q <= period_q;
                    cur_owner_q  <= owner_q;
                end
                WR_CTRL: state_q <= IDLE;
                CLR_STS: state_q <= IDLE;
                default: state_q <= BOOT;
            endcase
        end
    end

`ifdef TIMER_SEQ_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 16'd0;
        end else if (state_q == CLR_STS) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expired_count = cnt_q;
`else
    assign expired_count = 16'd0;
`endif

endmodule

// File: tb/tb_debug_timer_sequencer.sv
// Scoreboard bench for debug_timer_sequencer: expected timer writes and grants are queued
// by the stimulus and popped by a monitor whenever the DUT writes or raises a ready.
module tb_debug_timer_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_period = 32'd0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_period = 32'd0;
    logic        req1_ready;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq = 1'b0;
    logic        quantum_expired;
    logic [31:0] cur_period;
    logic        cur_owner;
    logic        busy;
    logic [15:0] expired_count;

    debug_timer_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req0_valid      (req0_valid),
        .req0_period     (req0_period),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_period     (req1_period),
        .req1_ready      (req1_ready),
        .tmr_address     (tmr_address),
        .tmr_chipselect  (tmr_chipselect),
        .tmr_write_n     (tmr_write_n),
        .tmr_writedata   (tmr_writedata),
        .tmr_irq         (tmr_irq),
        .quantum_expired (quantum_expired),
        .cur_period      (cur_period),
        .cur_owner       (cur_owner),
        .busy            (busy),
        .expired_count   (expired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic        qe;
        bit          consec;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_gr[$];
    int  vecs = 0;
    int  errs = 0;
    int  cyc = 0;
    int  last_evt = 0;
    int  n_irq = 0;
    wr_t e;
    int  g;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        vecs++;
        errs++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d,
                           input logic qe, input bit consec);
        wr_t w;
        w.a = a;
        w.d = d;
        w.qe = qe;
        w.consec = consec;
        exp_wr.push_back(w);
    endtask

    task automatic push_boot();
        push_wr(3'd2, 16'hC34F, 1'b0, 1'b0);
        push_wr(3'd3, 16'h0000, 1'b0, 1'b1);
        push_wr(3'd1, 16'h0007, 1'b0, 1'b1);
    endtask

    // monitor: pops the scoreboard on every timer write and every grant
    always @(negedge clk) begin
        if (reset_n) begin
            if (tmr_chipselect) begin
                if (exp_wr.size() == 0) begin
                    bad("unexpected_write");
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", {29'd0, tmr_address}, {29'd0, e.a});
                    chk("wr_data", {16'd0, tmr_writedata}, {16'd0, e.d});
                    chk("wr_n", {31'd0, tmr_write_n}, 32'd0);
                    chk("qe", {31'd0, quantum_expired}, {31'd0, e.qe});
                    if (e.consec)
                        chk("wr_latency", cyc, last_evt + 1);
                end
                last_evt = cyc;
            end else if (quantum_expired) begin
                bad("stray_qe");
            end
            if (req0_ready || req1_ready) begin
                chk("one_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
                if (exp_gr.size() == 0) begin
                    bad("unexpected_grant");
                end else begin
                    g = exp_gr.pop_front();
                    chk("grant", {31'd0, req1_ready}, g);
                end
                last_evt = cyc;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || tmr_chipselect) && n < 100);
        if (busy) bad("idle_timeout");
    endtask

    task automatic check_reset_outputs();
        chk("rst_cs", {31'd0, tmr_chipselect}, 32'd0);
        chk("rst_wn", {31'd0, tmr_write_n}, 32'd1);
        chk("rst_addr", {29'd0, tmr_address}, 32'd0);
        chk("rst_wd", {16'd0, tmr_writedata}, 32'd0);
        chk("rst_qe", {31'd0, quantum_expired}, 32'd0);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rst_period", cur_period, 32'd0);
        chk("rst_owner", {31'd0, cur_owner}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_count", {16'd0, expired_count}, 32'd0);
    endtask

    task automatic req(input int idx, input logic [31:0] p);
        logic [31:0] pc;
        int n = 0;
        pc = (p == 32'd0) ? 32'd1 : p;
        exp_gr.push_back(idx);
        push_wr(3'd2, pc[15:0], 1'b0, 1'b1);
        push_wr(3'd3, pc[31:16], 1'b0, 1'b1);
        push_wr(3'd1, 16'h0007, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        if (idx == 0) begin
            req0_valid = 1'b1;
            req0_period = p;
        end else begin
            req1_valid = 1'b1;
            req1_period = p;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(idx == 0 ? req0_ready : req1_ready) && n < 50);
        if (n >= 50) bad("ready_timeout");
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        chk("cur_period", cur_period, pc);
        chk("cur_owner", {31'd0, cur_owner}, idx);
    endtask

    task automatic irq_pulse();
        int n = 0;
        push_wr(3'd0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        tmr_irq = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!quantum_expired && n < 50);
        if (n >= 50) bad("qe_timeout");
        tmr_irq = 1'b0;
        n_irq++;
        wait_idle();
    endtask

    initial begin
        int n;
        int got;
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int got;
        logic [31:0] exp_cnt;

        push_boot();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;
        wait_idle();
        chk("boot_period", cur_period, 32'd49999);
        chk("boot_owner", {31'd0, cur_owner}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // tie: grants alternate starting with req0
        exp_gr.push_back(0);
        push_wr(3'd2, 16'h0100, 1'b0, 1'b1);
        push_wr(3'd3, 16'h0000, 1'b0, 1'b1);
        push_wr(3'd1, 16'h0007, 1'b0, 1'b1);
        exp_gr.push_back(1);
        push_wr(3'd2, 16'h0200, 1'b0, 1'b1);
        push_wr(3'd3, 16'h0000, 1'b0, 1'b1);
        push_wr(3'd1, 16'h0007, 1'b0, 1'b1);
        exp_gr.push_back(0);
        push_wr(3'd2, 16'h0100, 1'b0, 1'b1);
        push_wr(3'd3, 16'h0000, 1'b0, 1'b1);
        push_wr(3'd1, 16'h0007, 1'b0, 1'b1);
        exp_gr.push_back(1);
        push_wr(3'd2, 16'h0200, 1'b0, 1'b1);
        push_wr(3'd3, 16'h0000, 1'b0, 1'b1);
        push_wr(3'd1, 16'h0007, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_period = 32'h100;
        req1_valid = 1'b1;
        req1_period = 32'h200;
        got = 0;
        n = 0;
        while (got < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (req0_ready || req1_ready) got++;
        end
        if (got < 4) bad("tie_timeout");
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        chk("tie_period", cur_period, 32'h200);
        chk("tie_owner", {31'd0, cur_owner}, 32'd1);

        req(0, 32'h0001_86A0);

        // irq outranks a simultaneous request
        push_wr(3'd0, 16'h0000, 1'b1, 1'b0);
        exp_gr.push_back(1);
        push_wr(3'd2, 16'h0500, 1'b0, 1'b1);
        push_wr(3'd3, 16'h0000, 1'b0, 1'b1);
        push_wr(3'd1, 16'h0007, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        tmr_irq = 1'b1;
        req1_valid = 1'b1;
        req1_period = 32'h500;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!quantum_expired && n < 50);
        if (n >= 50) bad("irq_req_timeout");
        chk("irq_no_ready", {31'd0, req1_ready}, 32'd0);
        tmr_irq = 1'b0;
        n_irq++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req1_ready && n < 50);
        if (n >= 50) bad("req1_timeout");
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_idle();
        chk("irq_req_period", cur_period, 32'h500);
        chk("irq_req_owner", {31'd0, cur_owner}, 32'd1);

        req(0, 32'd0);

        irq_pulse();
        irq_pulse();
        irq_pulse();
`ifdef TIMER_SEQ_STATS_EN
        exp_cnt = n_irq;
`else
        exp_cnt = 32'd0;
`endif
        chk("expired_count", {16'd0, expired_count}, exp_cnt);

        // reset during WR_PH aborts the write sequence
        exp_gr.push_back(1);
        push_wr(3'd2, 16'h5678, 1'b0, 1'b1);
        push_wr(3'd3, 16'h1234, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        req1_valid = 1'b1;
        req1_period = 32'h1234_5678;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req1_ready && n < 50);
        if (n >= 50) bad("mid_ready_timeout");
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tmr_chipselect && tmr_address == 3'd3) && n < 50);
        if (n >= 50) bad("wr_ph_timeout");
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        chk("mid_queue", exp_wr.size(), 32'd0);
        push_boot();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_idle();
        chk("reboot_period", cur_period, 32'd49999);
        chk("reboot_owner", {31'd0, cur_owner}, 32'd0);
        repeat (3) @(negedge clk);
        chk("queues_empty", exp_wr.size() + exp_gr.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/debug_timer_sequencer.md
DEBUG_TIMER_SEQUENCER -- requirements
Module: debug_timer_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BOOT_PERIOD, 32'd49999, period programmed after reset.
- CTRL_WORD, 16'h0007, control word written on each programming: ITO, CONT, START set; STOP clear.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; one clock, all state on its rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- req0_valid / req1_valid  in  1  requester wants new timeslice period.
- req0_period / req1_period  in  32  requested period, in clk cycles.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- tmr_address  out  3  timer slave address.
- tmr_chipselect  out  1  timer slave select.
- tmr_write_n  out  1  timer write strobe, active-low.
- tmr_writedata  out  16  timer write data.
- tmr_irq  in  1  timer interrupt, level.
- quantum_expired  out  1  one-cycle pulse per serviced timeout.
- cur_period  out  32  last period programmed.
- cur_owner  out  1  requester index that owns cur_period.
- busy  out  1  high when state is not IDLE.
- expired_count  out  16  serviced-timeout count.

Function
REQ-003 FSM states SHALL be BOOT, IDLE, WR_PL, WR_PH, WR_CTRL, CLR_STS; each non-IDLE state SHALL last exactly one cycle.
REQ-004 BOOT SHALL load BOOT_PERIOD into the working period register and go to WR_PL.
REQ-005 WR_PL SHALL drive address 2 with period[15:0]; WR_PH SHALL drive address 3 with period[31:16]; WR_CTRL SHALL drive address 1 with CTRL_WORD. These three states SHALL run consecutively and WR_CTRL SHALL return to IDLE.
REQ-006 CLR_STS SHALL drive address 0 with data 0 and assert quantum_expired in the same cycle, then return to IDLE.
REQ-007 In each write state, tmr_chipselect SHALL be 1 and tmr_write_n SHALL be 0. Outside write states, chipselect SHALL be 1'b0, write_n 1'b1, address 3'd0 and writedata 16'd0.
REQ-008 In IDLE, tmr_irq=1 SHALL take priority: next state is CLR_STS and no ready is asserted.
REQ-009 In IDLE with tmr_irq=0, arbitration among valid requesters SHALL be round-robin.
- A single valid requester wins.
- If both are valid, the one not granted last wins.
- The last-grant pointer resets to 1, so req0 wins the first tie.
REQ-010 The winner's ready SHALL be combinationally high in that IDLE cycle; valid&&ready SHALL latch its period and index and go to WR_PL. The ready of the non-winner SHALL stay 0.
REQ-011 Latency from accept to control write SHALL be 3 cycles: WR_PL, WR_PH and WR_CTRL occur in accept+1, +2 and +3.
REQ-012 An accepted period of 0 SHALL be coerced to 1.
REQ-013 cur_period and cur_owner SHALL update at the WR_CTRL edge. After BOOT, cur_owner SHALL be 0.
REQ-014 An irq arriving while not in IDLE SHALL be serviced at the next IDLE cycle; it is never lost because the timer holds irq level.
REQ-015 Requests held while busy SHALL wait; there is no queueing beyond the valid/ready hold.
REQ-016 busy SHALL be high in all states except IDLE.

Reset
REQ-017 On reset_n=0 the FSM SHALL enter BOOT, and the following SHALL be 0 asynchronously:
- readys, quantum_expired, tmr_chipselect, tmr_address, tmr_writedata, cur_owner, expired_count.
- tmr_write_n SHALL be 1 and cur_period SHALL be 32'd0.
REQ-018 After release, the boot sequence (BOOT, WR_PL, WR_PH, WR_CTRL) SHALL complete before any request or irq is serviced. Reset mid-sequence SHALL abort it and restart from BOOT.

Configuration
REQ-019 With macro TIMER_SEQ_STATS_EN defined, expired_count SHALL increment by 1 on each CLR_STS cycle, wrapping 16'hFFFF->0. Without it, expired_count SHALL be constant 0 and no counter SHALL be built.

Verification
REQ-020 Reset release -> BOOT, then writes (2,0xC34F), (3,0x0000), (1,0x0007) on 3 consecutive cycles; cur_period=49999.
REQ-021 req0_valid with period 0x0001_86A0 in IDLE -> req0_ready same cycle, then writes (2,0x86A0), (3,0x0001), (1,0x0007); cur_owner=0.
REQ-022 req0 and req1 both valid repeatedly -> grants alternate 0,1,0,1; the non-winner's ready stays 0.
REQ-023 tmr_irq=1 together with req1_valid in IDLE -> CLR_STS write (0,0x0000) and quantum_expired pulse first; req1 accepted the following IDLE cycle.
REQ-024 req0 with period 0 -> writes (2,0x0001), (3,0x0000); with TIMER_SEQ_STATS_EN, 3 irqs -> expired_count=3.
REQ-025 reset_n asserted during WR_PH -> outputs idle immediately; after release, full boot sequence reruns.
